pb_conditioner: RTL and testbench
=================================

Name: pb_conditioner

Overview:
- Conditions the raw board pushbuttons before they reach the game/VGA controller paddle logic.
- Per button: 2-FF synchroniser, polarity normalisation, counter-based debounce, and single-cycle press/release pulses.
- Sits between the top-level pb pins and the controller. The controller consumes pb_level for held-paddle motion and pb_press for serve/start events.

Parameters:
- NUM_BTN, 4: number of independent buttons.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required to accept a change (20 ms at 50 MHz). Minimum 2.
- PB_ACTIVE_LOW, 1: 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- REPEAT_DELAY_CYC, 25000000: hold time before the first auto-repeat pulse. Used only with PB_REPEAT_EN.
- REPEAT_PERIOD_CYC, 5000000: spacing between subsequent auto-repeat pulses. Used only with PB_REPEAT_EN.

Ports:
- clk, input, 1: system clock, 50 MHz; all logic on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- pb_raw, input, NUM_BTN: asynchronous raw button pins.
- pb_level, output, NUM_BTN: debounced level; 1 = pressed.
- pb_press, output, NUM_BTN: one-cycle pulse on each accepted press.
- pb_release, output, NUM_BTN: one-cycle pulse on each accepted release.

Behaviour:
- Reset: all outputs 0. Every synchroniser stage is loaded with the released pin value (1 if PB_ACTIVE_LOW, else 0). Every stable state = released. All counters = 0.
- Reset is sampled only on clk edges. Asserting it mid-debounce aborts the count, with no pulse emitted.
- Synchroniser: two flops per bit. Normalised sample s[i] = sync2[i] XOR PB_ACTIVE_LOW.
- Per-button debounce, one counter each, width clog2(DEBOUNCE_CYC+1):
  - If s[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYC-1: stable[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- A single cycle of agreement restarts the count (glitch rejection). The counter never wraps.
- pb_level = stable, registered.
- pb_press[i] is registered high for exactly one cycle, in the same cycle pb_level[i] goes 0->1. pb_release[i] likewise on 1->0.
- pb_press and pb_release are never high together for the same bit.
- Latency: a clean raw edge held steady appears on pb_level/pulse exactly DEBOUNCE_CYC+2 rising edges after the first edge that samples the new pin value.
- Buttons are fully independent. Simultaneous events on several bits produce their pulses in the same cycle.
- A button held through reset deassertion is treated as a new press and pulses DEBOUNCE_CYC+2 edges after rst goes high.
- Per-button state machine:
  - IDLE: released, cnt = 0.
  - PEND_PRESS: counting toward pressed. Goes to PRESSED on expiry, or back to IDLE on disagreement.
  - PRESSED.
  - PEND_RELEASE: goes to IDLE on expiry, or back to PRESSED on disagreement.

Optional Feature:
- Macro PB_REPEAT_EN.
- Defined: each button gets a repeat counter that starts at the accepted press pulse.
  - While pb_level[i] stays 1, pb_press[i] pulses again REPEAT_DELAY_CYC cycles after the original pulse.
  - It then pulses every REPEAT_PERIOD_CYC cycles.
  - An accepted release, or reset, clears the counter immediately. No repeat pulse may coincide with pb_release.
- Undefined: exactly one pb_press pulse per accepted press. No repeat counters are synthesised.

Test Plan (DEBOUNCE_CYC=8, PB_ACTIVE_LOW=1, NUM_BTN=4):
- Reset: rst=0 for 3 cycles with pb_raw=4'b1111 -> pb_level=0, pb_press=0, pb_release=0; they stay 0 for 20 cycles after rst=1.
- Clean press/release: pb_raw[0] 1->0, held 20 cycles -> pb_level[0] rises and pb_press[0] pulses for 1 cycle, 10 edges after the change. Then pb_raw[0] 0->1 -> pb_release[0] pulse and pb_level[0] fall 10 edges later.
- Bounce: pb_raw[1] toggles every 3 cycles for 40 cycles, then holds 0 -> no pulses during toggling; exactly one pb_press[1] 10 edges after the final settle.
- Simultaneous: pb_raw 4'b1111 -> 4'b0011 in one cycle -> pb_press=4'b1100 in one cycle, 10 edges later; bits 0 and 1 remain 0.
- Reset mid-count: pb_raw[2]=0, rst=0 at count 5 for 2 cycles, pb_raw held 0 -> no pulse before reset. After rst=1, pb_press[2] pulses 10 edges later.
- With PB_REPEAT_EN, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=6: pb_raw[3] held 0 -> pb_press[3] pulses at t0, t0+20, t0+26, t0+32. After release is accepted -> no further pulses.

Source files
------------

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - pushbutton synchroniser, debouncer and press/release pulse generator
// Define PB_REPEAT_EN to add auto-repeat pb_press pulses while a button is held.
module pb_conditioner #(
  parameter int NUM_BTN           = 4,
  parameter int DEBOUNCE_CYC      = 1000000,
  parameter int PB_ACTIVE_LOW     = 1,
  parameter int REPEAT_DELAY_CYC  = 25000000,
  parameter int REPEAT_PERIOD_CYC = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_raw,
  output logic [NUM_BTN-1:0] pb_level,
  output logic [NUM_BTN-1:0] pb_press,
  output logic [NUM_BTN-1:0] pb_release
);

  localparam int                 CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [NUM_BTN-1:0] REL_PIN  = (PB_ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  typedef enum logic [1:0] {IDLE, PEND_PRESS, PRESSED, PEND_RELEASE} btn_state_e;

  logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  logic [NUM_BTN-1:0] s, stable, acc_press, acc_release, rpt_pulse;
  btn_state_e         state_q [NUM_BTN];
  btn_state_e         state_d [NUM_BTN];
  logic [CW-1:0]      cnt_q   [NUM_BTN];
  logic [CW-1:0]      cnt_d   [NUM_BTN];

  assign pb_level   = level_q;
  assign pb_press   = press_q;
  assign pb_release = release_q;

  // s is 1 when the synchronised pin reads "pressed", whatever the board polarity
  always_comb begin
    sync1_d = pb_raw;
    sync2_d = sync1_q;
    s       = sync2_q ^ REL_PIN;
    for (int i = 0; i < NUM_BTN; i++) begin
      stable[i]      = (state_q[i] == PRESSED) || (state_q[i] == PEND_RELEASE);
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      acc_press[i]   = 1'b0;
      acc_release[i] = 1'b0;
      if (s[i] == stable[i]) begin
        cnt_d[i]   = '0;
        state_d[i] = stable[i] ? PRESSED : IDLE;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]       = '0;
        state_d[i]     = s[i] ? PRESSED : IDLE;
        acc_press[i]   = s[i];
        acc_release[i] = ~s[i];
      end else begin
        cnt_d[i]   = cnt_q[i] + CW'(1);
        state_d[i] = stable[i] ? PEND_RELEASE : PEND_PRESS;
      end
    end
    level_d   = (stable & ~acc_release) | acc_press;
    press_d   = acc_press | rpt_pulse;
    release_d = acc_release;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= REL_PIN;
      sync2_q   <= REL_PIN;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef PB_REPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                              REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC) + 1);

  logic [RW-1:0]      rpt_cnt_q [NUM_BTN];
  logic [RW-1:0]      rpt_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_first_q, rpt_first_d;

  // rpt_first selects the long initial delay; later pulses use the shorter period
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      rpt_pulse[i]   = 1'b0;
      if (acc_press[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b1;
      end else if (!stable[i] || acc_release[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end else if (rpt_first_q[i] ? (rpt_cnt_q[i] == RW'(REPEAT_DELAY_CYC - 1))
                                  : (rpt_cnt_q[i] == RW'(REPEAT_PERIOD_CYC - 1))) begin
        rpt_pulse[i]   = 1'b1;
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_first_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  assign rpt_pulse = '0;
`endif

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - directed vector bench for pb_conditioner
// Each table row holds inputs for ncyc cycles and the outputs expected after every edge.
module tb_pb_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pb_raw = 4'hF;
  logic [3:0] pb_level, pb_press, pb_release;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pb_conditioner #(
    .NUM_BTN(4), .DEBOUNCE_CYC(8), .PB_ACTIVE_LOW(1),
    .REPEAT_DELAY_CYC(20), .REPEAT_PERIOD_CYC(6)
  ) dut (
    .clk(clk), .rst(rst), .pb_raw(pb_raw),
    .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] raw;
    int         ncyc;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] raw, input int n,
                     input logic [3:0] l, input logic [3:0] p, input logic [3:0] q);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.ncyc = n; v.lvl = l; v.prs = p; v.rls = q;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] raw);
    @(negedge clk);
    rst    = r;
    pb_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp, input int idx);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  initial begin
    logic exp_p, exp_r, exp_l;

    // reset, then idle with all pins released
    add(0, 4'hF, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 20, 4'h0, 4'h0, 4'h0);
    // clean press/release on bit 0
    add(1, 4'hE, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 1, 4'h1, 4'h1, 4'h0);
    add(1, 4'hE, 10, 4'h1, 4'h0, 4'h0);
    add(1, 4'hF, 9, 4'h1, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h1);
    add(1, 4'hF, 5, 4'h0, 4'h0, 4'h0);
    // bit 1 bounces every 3 cycles, then settles pressed
    for (int k = 0; k < 14; k++) add(1, (k % 2 == 0) ? 4'hD : 4'hF, 3, 4'h0, 4'h0, 4'h0);
    add(1, 4'hD, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'hD, 1, 4'h2, 4'h2, 4'h0);
    add(1, 4'hD, 5, 4'h2, 4'h0, 4'h0);
    add(1, 4'hF, 9, 4'h2, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h2);
    add(1, 4'hF, 5, 4'h0, 4'h0, 4'h0);
    // bits 2 and 3 together
    add(1, 4'h3, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'h3, 1, 4'hC, 4'hC, 4'h0);
    add(1, 4'h3, 5, 4'hC, 4'h0, 4'h0);
    add(1, 4'hF, 9, 4'hC, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'hC);
    add(1, 4'hF, 5, 4'h0, 4'h0, 4'h0);
    // one-cycle glitch just as the count would expire restarts it
    add(1, 4'hE, 7, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 1, 4'h1, 4'h1, 4'h0);
    add(1, 4'hE, 3, 4'h1, 4'h0, 4'h0);
    add(1, 4'hF, 9, 4'h1, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h1);
    add(1, 4'hF, 3, 4'h0, 4'h0, 4'h0);
    // reset at count 5 aborts, button held through reset re-presses
    add(1, 4'hB, 7, 4'h0, 4'h0, 4'h0);
    add(0, 4'hB, 2, 4'h0, 4'h0, 4'h0);
    add(1, 4'hB, 9, 4'h0, 4'h0, 4'h0);
    add(1, 4'hB, 1, 4'h4, 4'h4, 4'h0);
    add(1, 4'hB, 8, 4'h4, 4'h0, 4'h0);
    add(1, 4'hF, 9, 4'h4, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h4);
    add(1, 4'hF, 3, 4'h0, 4'h0, 4'h0);

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].ncyc; c++) begin
        step(vecs[k].rst_n, vecs[k].raw);
        check("level", pb_level, vecs[k].lvl, k);
        check("press", pb_press, vecs[k].prs, k);
        check("release", pb_release, vecs[k].rls, k);
      end
    end

    // long hold on bit 3: press at 9, repeats (if enabled) at 29/35/41, release at 43
    for (int c = 0; c < 70; c++) begin
      step(1'b1, (c < 34) ? 4'h7 : 4'hF);
      exp_p = (c == 9);
`ifdef PB_REPEAT_EN
      exp_p = exp_p || (c == 29) || (c == 35) || (c == 41);
`endif
      exp_r = (c == 43);
      exp_l = (c >= 9) && (c < 43);
      check("hold_press", pb_press, {exp_p, 3'b000}, c);
      check("hold_release", pb_release, {exp_r, 3'b000}, c);
      check("hold_level", pb_level, {exp_l, 3'b000}, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
